// File: rtl/addsub_accum_pkg.sv
// Shared types and constants for the streaming add/sub accumulator and its
// combinational add/sub datapath.
package addsub_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic ADD_OP = 1'b1;
    localparam logic SUB_OP = 1'b0;

    localparam int unsigned ADDSUB_WIDTH = 36;
    localparam int unsigned ACCUM_CNT_W  = 8;

    // Two's-complement overflow from the sign bits of the operands and result.
    // A subtract behaves as an add of the inverted operand, so only its sign flips.
    function automatic logic signed_ovf(
        input logic acc_msb,
        input logic opd_msb,
        input logic res_msb,
        input logic add
    );
        logic eff_msb;
        eff_msb    = (add == ADD_OP) ? opd_msb : ~opd_msb;
        signed_ovf = (acc_msb == eff_msb) && (res_msb != acc_msb);
    endfunction

endpackage

// File: rtl/addsub_ovf.sv
// Combinational add/subtract of an operand into an accumulator value,
// producing the truncated result and a signed-overflow flag.
module addsub_ovf
    import addsub_accum_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             add,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf
);

    logic [WIDTH-1:0] operand_eff;
    logic [WIDTH-1:0] carry_in;

    always_comb begin
        operand_eff = (add == ADD_OP) ? operand : ~operand;
        carry_in    = {{(WIDTH-1){1'b0}}, (add == SUB_OP)};
        nxt         = acc + operand_eff + carry_in;
        ovf         = signed_ovf(acc[WIDTH-1], operand[WIDTH-1], nxt[WIDTH-1], add);
    end

endmodule

// File: rtl/addsub_accum.sv
// Streaming add/sub accumulator: folds beats into a running sum, emits sum/count/overflow per frame.
// Latency: result valid in the cycle after the last beat is accepted.
// Backpressure: in_ready is low while a result waits in the output register (no bypass).
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH,
    parameter int unsigned CNT_W = ACCUM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_add,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             res_hs;
    logic [WIDTH-1:0] beat_sum;
    logic             beat_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_acc;

    addsub_ovf #(
        .WIDTH (WIDTH)
    ) u_addsub_ovf (
        .acc     (acc_q),
        .operand (in_data),
        .add     (in_add),
        .nxt     (beat_sum),
        .ovf     (beat_ovf)
    );

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Output process: handshake signals follow the state.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = out_valid_q;
        out_sum   = out_sum_q;
        out_count = out_count_q;
        out_ovf   = out_ovf_q;
    end

    always_comb begin
        accept  = in_valid && in_ready;
        res_hs  = out_valid_q && out_ready;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        ovf_acc = ovf_q | beat_ovf;
    end

    // Next-state process.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (res_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accept and handshake never coincide: accept needs in_ready, which is low in HOLD.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            if (in_last) begin
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
                out_sum_d   = beat_sum;
                out_count_d = cnt_inc;
                out_ovf_d   = ovf_acc;
            end else begin
                acc_d = beat_sum;
                cnt_d = cnt_inc;
                ovf_d = ovf_acc;
            end
        end

        if (res_hs) begin
            out_valid_d = 1'b0;
        end
    end

endmodule
